const_map_ctrl: RTL

//  Sequences scrambled NPUSCH bits into the two-read-port constellation ROM and emits one registered
//  I/Q symbol per BPSK (1 bit) or QPSK (2 bits) group. Sits between the scrambler and the resource mapper.

---
 rtl/const_map_pkg.sv | 26 ++
 rtl/const_map_ctrl_flexrom2.sv | 31 +++
 rtl/const_map_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/const_map_pkg.sv
// Shared types and constants for the constellation mapper slice.
// mode_e  : modulation selected at frame start
// state_e : sequencing FSM states of const_map_ctrl
// ROM index constants and the Q2.14 +/-1/sqrt2 words stored in flexrom2.
package const_map_pkg;

  typedef enum logic {
    MODE_BPSK = 1'b0,
    MODE_QPSK = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned ADDR_POS_INV_SQRT2 = 0;
  localparam int unsigned ADDR_NEG_INV_SQRT2 = 1;

  // Q2.14 representation of +1/sqrt2 and -1/sqrt2
  localparam logic [15:0] C_POS_INV_SQRT2 = 16'h2D41;
  localparam logic [15:0] C_NEG_INV_SQRT2 = 16'hD2BF;

endpackage

// File: rtl/const_map_ctrl_flexrom2.sv
// flexrom2: two-read-port combinational constellation ROM.
// Ports:
//   addr1/addr2 : read addresses (ADDR_WIDTH)
//   dout1/dout2 : read data (DATA_WIDTH), entry 0 = +1/sqrt2, 1 = -1/sqrt2,
//                 entries 2/3 reserved and read as zero.
module flexrom2
  import const_map_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic [DATA_WIDTH-1:0] dout2
);

  function automatic logic [DATA_WIDTH-1:0] lookup(input logic [ADDR_WIDTH-1:0] a);
    case (a)
      ADDR_WIDTH'(ADDR_POS_INV_SQRT2): return DATA_WIDTH'(C_POS_INV_SQRT2);
      ADDR_WIDTH'(ADDR_NEG_INV_SQRT2): return DATA_WIDTH'(C_NEG_INV_SQRT2);
      default:                         return '0;
    endcase
  endfunction

  always_comb begin
    dout1 = lookup(addr1);
    dout2 = lookup(addr2);
  end

endmodule

// File: rtl/const_map_ctrl.sv
// const_map_ctrl: sequences scrambled bits into the constellation ROM and
// emits one registered I/Q symbol per BPSK (1 bit) or QPSK (2 bit) group.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start, i_mode, i_num_syms  frame start (IDLE only), mode and symbol count
//   i_bit, i_bit_valid, o_bit_ready  bit input handshake
//   o_sym_i, o_sym_q, o_sym_valid, i_sym_ready  symbol output handshake
//   o_busy                    high outside IDLE
//   o_done                    one-cycle pulse after the last symbol is taken
// Build option: define PI2_ROT_EN to rotate odd-indexed symbols by +90 deg.
module const_map_ctrl
  import const_map_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [CNT_WIDTH-1:0]  i_num_syms,
  input  logic                  i_bit,
  input  logic                  i_bit_valid,
  output logic                  o_bit_ready,
  output logic [DATA_WIDTH-1:0] o_sym_i,
  output logic [DATA_WIDTH-1:0] o_sym_q,
  output logic                  o_sym_valid,
  input  logic                  i_sym_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  state_e                  state, state_nxt;
  mode_e                   mode_q;
  logic [CNT_WIDTH-1:0]    num_q;
  logic [CNT_WIDTH-1:0]    cnt;
  logic                    first_bit;
  logic                    have_first;
  logic                    bit_acc;
  logic                    load;
  logic                    last_load;
  logic                    b_i, b_q;
  logic [ADDR_WIDTH-1:0]   addr_i, addr_q;
  logic [DATA_WIDTH-1:0]   rom_i, rom_q;

  assign bit_acc = i_bit_valid && o_bit_ready;

  // Group assembly: QPSK pairs the stored first bit (I) with the current bit (Q).
  always_comb begin
    b_i  = i_bit;
    b_q  = i_bit;
    load = 1'b0;
    if (mode_q == MODE_QPSK) begin
      b_i  = first_bit;
      load = bit_acc && have_first;
    end else begin
      load = bit_acc;
    end
  end

  assign last_load = load && (cnt == num_q - CNT_WIDTH'(1));

  always_comb begin
    addr_i = {{(ADDR_WIDTH-1){1'b0}}, b_i};
    addr_q = {{(ADDR_WIDTH-1){1'b0}}, b_q};
`ifdef PI2_ROT_EN
    // +90 deg on odd symbols: (I,Q) -> (-Q,I); negation is a sign-bit flip.
    if (cnt[0]) begin
      addr_i = {{(ADDR_WIDTH-1){1'b0}}, ~b_q};
      addr_q = {{(ADDR_WIDTH-1){1'b0}}, b_i};
    end
`endif
  end

  flexrom2 #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rom (
    .addr1(addr_i),
    .addr2(addr_q),
    .dout1(rom_i),
    .dout2(rom_q)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_start) state_nxt = (i_num_syms == '0) ? DONE : RUN;
      RUN:   if (last_load) state_nxt = DRAIN;
      DRAIN: if (o_sym_valid && i_sym_ready) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_bit_ready = (state == RUN) && (!o_sym_valid || i_sym_ready);
    o_busy      = (state != IDLE);
    o_done      = (state == DONE);
  end

  // Frame configuration, bit collector and symbol counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q     <= MODE_BPSK;
      num_q      <= '0;
      cnt        <= '0;
      first_bit  <= 1'b0;
      have_first <= 1'b0;
    end else begin
      if (state == IDLE && i_start) begin
        mode_q     <= mode_e'(i_mode);
        num_q      <= i_num_syms;
        cnt        <= '0;
        first_bit  <= 1'b0;
        have_first <= 1'b0;
      end else begin
        if (bit_acc) begin
          if (mode_q == MODE_QPSK && !have_first) begin
            first_bit  <= i_bit;
            have_first <= 1'b1;
          end else begin
            have_first <= 1'b0;
          end
        end
        if (load) cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

  // One-deep output register; a load in the acceptance cycle keeps valid high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sym_i     <= '0;
      o_sym_q     <= '0;
      o_sym_valid <= 1'b0;
    end else if (load) begin
      o_sym_i     <= rom_i;
      o_sym_q     <= rom_q;
      o_sym_valid <= 1'b1;
    end else if (i_sym_ready) begin
      o_sym_valid <= 1'b0;
    end
  end

endmodule
